// File: rtl/armstrong_gen.sv
// rtl/armstrong_gen.sv - scans [lo,hi] and streams Armstrong numbers in ascending order
// Optional live found-counter on count: ARMGEN_COUNT_EN
module armstrong_gen #(
    parameter int WIDTH = 10,
    parameter int NDIG  = 4,
    parameter int SUMW  = 16,
    parameter int CNTW  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_num,
    output logic             done,
    output logic [CNTW-1:0]  count
);
    localparam int DW = $clog2(NDIG + 1);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CONV, S_SETUP, S_POW, S_CMP, S_EMIT, S_NEXT, S_DONE
    } state_t;

    state_t            state;
    logic [WIDTH-1:0]  hi_q;
    logic [WIDTH-1:0]  cand;
    logic [WIDTH-1:0]  shreg;
    logic [4*NDIG-1:0] bcd;
    logic [4*NDIG-1:0] bcd_adj;
    logic [4*NDIG-1:0] bcd_inc;
    logic [CW-1:0]     conv_cnt;
    logic [DW-1:0]     n;
    logic [DW-1:0]     n_calc;
    logic [DW-1:0]     i;
    logic [DW-1:0]     j;
    logic [SUMW-1:0]   sum;
    logic [SUMW-1:0]   pw;
    logic [SUMW-1:0]   pw_next;
    logic [3:0]        dig;

    // Double-dabble add-3 correction and decimal increment, per BCD digit
    always_comb begin
        logic carry;
        bcd_adj = '0;
        bcd_inc = '0;
        n_calc  = '0;
        dig     = '0;
        carry   = 1'b1;
        for (int k = 0; k < NDIG; k++) begin
            bcd_adj[4*k +: 4] = (bcd[4*k +: 4] >= 4'd5) ? bcd[4*k +: 4] + 4'd3 : bcd[4*k +: 4];
            if (carry) begin
                if (bcd[4*k +: 4] == 4'd9) begin
                    bcd_inc[4*k +: 4] = 4'd0;
                end else begin
                    bcd_inc[4*k +: 4] = bcd[4*k +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end else begin
                bcd_inc[4*k +: 4] = bcd[4*k +: 4];
            end
            if (bcd[4*k +: 4] != 4'd0) n_calc = DW'(k + 1);
            if (i == DW'(k)) dig = bcd[4*k +: 4];
        end
    end

    assign pw_next = pw * {{(SUMW-4){1'b0}}, dig};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            done      <= 1'b0;
            out_num   <= '0;
            hi_q      <= '0;
            cand      <= '0;
            shreg     <= '0;
            bcd       <= '0;
            conv_cnt  <= '0;
            n         <= '0;
            i         <= '0;
            j         <= '0;
            sum       <= '0;
            pw        <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        hi_q     <= hi;
                        cand     <= lo;
                        shreg    <= lo;
                        bcd      <= '0;
                        conv_cnt <= '0;
                        if (lo > hi) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= S_CONV;
                            busy  <= 1'b1;
                        end
                    end
                end
                S_CONV: begin
                    bcd      <= {bcd_adj[4*NDIG-2:0], shreg[WIDTH-1]};
                    shreg    <= {shreg[WIDTH-2:0], 1'b0};
                    conv_cnt <= conv_cnt + 1'b1;
                    if (conv_cnt == CW'(WIDTH - 1)) state <= S_SETUP;
                end
                S_SETUP: begin
                    n     <= n_calc;
                    sum   <= '0;
                    i     <= '0;
                    j     <= '0;
                    pw    <= SUMW'(1);
                    state <= (n_calc == '0) ? S_CMP : S_POW;
                end
                S_POW: begin
                    // Last of n steps folds the final multiply straight into the sum
                    if (j == n - DW'(1)) begin
                        sum <= sum + pw_next;
                        pw  <= SUMW'(1);
                        j   <= '0;
                        if (i == n - DW'(1)) state <= S_CMP;
                        else                 i     <= i + 1'b1;
                    end else begin
                        pw <= pw_next;
                        j  <= j + 1'b1;
                    end
                end
                S_CMP: begin
                    if (sum == {{(SUMW-WIDTH){1'b0}}, cand}) begin
                        out_valid <= 1'b1;
                        out_num   <= cand;
                        state     <= S_EMIT;
                    end else begin
                        state <= S_NEXT;
                    end
                end
                S_EMIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (cand == hi_q) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        cand  <= cand + 1'b1;
                        bcd   <= bcd_inc;
                        state <= S_SETUP;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef ARMGEN_COUNT_EN
    logic [CNTW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (state == S_IDLE && start) begin
            cnt_q <= '0;
        end else if (state == S_EMIT && out_ready && cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign count = cnt_q;
`else
    assign count = '0;
`endif

endmodule

// File: tb/tb_armstrong_gen.sv
// tb/tb_armstrong_gen.sv - directed scoreboard bench for armstrong_gen
module tb_armstrong_gen;
    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [9:0] lo;
    logic [9:0] hi;
    logic       busy;
    logic       out_valid;
    logic       out_ready;
    logic [9:0] out_num;
    logic       done;
    logic [7:0] count;

    int checks   = 0;
    int failures = 0;
    logic [9:0] exp_q[$];

`ifdef ARMGEN_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    armstrong_gen dut (
        .clk(clk), .rst(rst), .start(start), .lo(lo), .hi(hi),
        .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
        .out_num(out_num), .done(done), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [9:0] l, input logic [9:0] h);
        lo    = l;
        hi    = h;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Consume outputs against the scoreboard until done; optionally stall on one value
    task automatic drain(input int budget, input logic [9:0] stall_num, input int stall_len);
        int stalled  = 0;
        int held     = 0;
        bit got_done = 1'b0;
        for (int c = 0; c < budget && !got_done; c++) begin
            if (done) begin
                got_done = 1'b1;
                chk("done_busy", busy, 0);
                chk("done_leftover", exp_q.size(), 0);
                out_ready = 1'b1;
                @(negedge clk);
                chk("done_width", done, 0);
            end else begin
                if (out_valid) begin
                    if (stall_len > 0 && out_num == stall_num) held++;
                    if (stall_len > 0 && out_num == stall_num && stalled < stall_len) begin
                        out_ready = 1'b0;
                        stalled++;
                    end else begin
                        out_ready = 1'b1;
                        chk("out_expected", exp_q.size() > 0, 1);
                        if (exp_q.size() > 0) chk("out_num", out_num, exp_q.pop_front());
                    end
                end
                @(negedge clk);
            end
        end
        chk("done_seen", got_done, 1);
        if (stall_len > 0) chk("stall_held", held, stall_len + 1);
    endtask

    initial begin
        int seen;
        logic [9:0] t1 [14] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 153, 370, 371, 407};
        rst       = 1'b1;
        start     = 1'b0;
        lo        = '0;
        hi        = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_num", out_num, 0);
        chk("rst_count", count, 0);
        rst = 1'b0;
        @(negedge clk);

        // full range
        foreach (t1[k]) exp_q.push_back(t1[k]);
        do_start(10'd0, 10'd1023);
        chk("t1_busy", busy, 1);
        drain(20000, 10'd0, 0);
        chk("t1_count", count, CNT_EN ? 14 : 0);

        // backpressure on 153
        exp_q.push_back(10'd153);
        exp_q.push_back(10'd370);
        exp_q.push_back(10'd371);
        do_start(10'd150, 10'd400);
        drain(5000, 10'd153, 5);
        chk("t2_count", count, CNT_EN ? 3 : 0);

        // empty range
        do_start(10'd500, 10'd300);
        chk("t3_busy", busy, 0);
        drain(20, 10'd0, 0);

        // top of range must not wrap
        do_start(10'd1023, 10'd1023);
        drain(200, 10'd0, 0);
        seen = 0;
        for (int c = 0; c < 30; c++) begin
            if (out_valid || busy) seen++;
            @(negedge clk);
        end
        chk("t4_no_wrap", seen, 0);
        chk("t4_count", count, 0);

        // reset while holding 153
        out_ready = 1'b0;
        do_start(10'd150, 10'd400);
        seen = 0;
        for (int c = 0; c < 500 && !out_valid; c++) @(negedge clk);
        chk("t5_valid", out_valid, 1);
        chk("t5_num", out_num, 153);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_rst_valid", out_valid, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_done", done, 0);
        rst       = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        exp_q.push_back(10'd370);
        exp_q.push_back(10'd371);
        do_start(10'd370, 10'd371);
        drain(500, 10'd0, 0);

        // start while busy is ignored
        exp_q.push_back(10'd153);
        exp_q.push_back(10'd370);
        exp_q.push_back(10'd371);
        do_start(10'd150, 10'd400);
        repeat (10) @(negedge clk);
        chk("t6_busy", busy, 1);
        chk("t6_quiet", out_valid, 0);
        do_start(10'd0, 10'd9);
        drain(5000, 10'd0, 0);
        chk("t6_count", count, CNT_EN ? 3 : 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
